// File: rtl/csa_pipe_pkg.sv
// ---------------------------------------------------------------------------
// csa_pipe_pkg
// Shared definitions for the pipelined carry-select adder (csa_pipe_adder).
//   calc_num_blk() : number of carry-select blocks (= pipeline stages)
//   geometry_ok()  : true when WIDTH is a non-zero multiple of BLK
//   stage_ctl_t    : per-stage registered carry and valid bundle
// ---------------------------------------------------------------------------
package csa_pipe_pkg;

  function automatic int calc_num_blk(input int width, input int blk);
    return width / blk;
  endfunction

  function automatic bit geometry_ok(input int width, input int blk);
    return (blk > 0) && (width >= blk) && ((width % blk) == 0);
  endfunction

  typedef struct packed {
    logic carry;  // carry out of the most recently resolved block
    logic valid;  // this stage holds a live operation
  } stage_ctl_t;

endpackage

// File: rtl/csa_pipe_adder_if.sv
// ---------------------------------------------------------------------------
// csa_pipe_adder_if
// Streaming handshake bundle for csa_pipe_adder.
//   flush              : synchronous clear of all in-flight operations
//   in_valid/in_ready  : operand handshake carrying a, b, cin
//   out_valid/out_ready: result handshake carrying sum, cout
// With CSA_PIPE_SUB_EN defined the bundle also carries sub (operand side)
// and ovf (result side, signed overflow).
// Modports: slave = adder view, master = producer/consumer view.
// ---------------------------------------------------------------------------
interface csa_pipe_adder_if #(
  parameter int WIDTH = 32
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef CSA_PIPE_SUB_EN
  logic             sub;
  logic             ovf;

  modport slave (
    input  flush, in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
  modport master (
    output flush, in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );
`else
  modport slave (
    input  flush, in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );
  modport master (
    output flush, in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );
`endif
endinterface

// File: rtl/csa_block.sv
// ---------------------------------------------------------------------------
// csa_block
// Combinational carry-select block of BLK bits. Both carry-in variants are
// computed up front so the late-arriving carry only drives a mux.
//   a, b      : operand slices
//   carry_in  : incoming carry (selects the precomputed variant)
//   sum       : BLK-bit result slice
//   carry_out : carry out of the slice
// ---------------------------------------------------------------------------
module csa_block #(
  parameter int BLK = 8
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           carry_in,
  output logic [BLK-1:0] sum,
  output logic           carry_out
);
  logic [BLK:0] s0;
  logic [BLK:0] s1;

  assign s0 = {1'b0, a} + {1'b0, b};
  assign s1 = {1'b0, a} + {1'b0, b} + (BLK+1)'(1);

  assign {carry_out, sum} = carry_in ? s1 : s0;
endmodule

// File: rtl/csa_pipe_adder.sv
// ---------------------------------------------------------------------------
// csa_pipe_adder
// Pipelined carry-select adder: sum = a + b + cin (mod 2^WIDTH), one BLK-bit
// block resolved per stage, latency NUM_BLK cycles, one result per cycle.
// The whole pipe advances as one (adv = !out_valid || out_ready); bubbles
// are not collapsed.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : csa_pipe_adder_if.slave (flush, operand and result handshakes)
// Optional feature (macro CSA_PIPE_SUB_EN): bus.sub selects a - b, with cin
// acting as active-low borrow-in; bus.ovf flags signed overflow.
// ---------------------------------------------------------------------------
module csa_pipe_adder
  import csa_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BLK   = 8
) (
  input logic            clk,
  input logic            rst,
  csa_pipe_adder_if.slave bus
);
  localparam int NUM_BLK = calc_num_blk(WIDTH, BLK);
  localparam int LAST    = NUM_BLK - 1;

  if (!geometry_ok(WIDTH, BLK)) begin : g_bad_geometry
    $error("csa_pipe_adder: WIDTH must be a non-zero multiple of BLK");
  end

  // Stage k register: a_q[k] holds completed sum bits below (k+1)*BLK and
  // still-unprocessed operand-a bits above; b_q[k] carries operand b along.
  logic [WIDTH-1:0] a_q   [NUM_BLK];
  logic [WIDTH-1:0] b_q   [NUM_BLK];
  stage_ctl_t       ctl_q [NUM_BLK];

  logic [WIDTH-1:0] a_in  [NUM_BLK];
  logic [WIDTH-1:0] b_in  [NUM_BLK];
  logic             c_in  [NUM_BLK];
  logic             v_in  [NUM_BLK];
  logic [WIDTH-1:0] a_nx  [NUM_BLK];
  logic [BLK-1:0]   s_w   [NUM_BLK];
  logic             co_w  [NUM_BLK];

  logic             adv;
  logic [WIDTH-1:0] b_first;
  logic             c_first;

  assign adv          = !ctl_q[LAST].valid || bus.out_ready;
  assign bus.in_ready = adv;

`ifdef CSA_PIPE_SUB_EN
  // Subtract as a + ~b + 1; cin is an active-low borrow-in, so cin=0 gives a-b.
  assign b_first = bus.sub ? ~bus.b : bus.b;
  assign c_first = bus.sub ? ~bus.cin : bus.cin;
`else
  assign b_first = bus.b;
  assign c_first = bus.cin;
`endif

  // Stage inputs: stage 0 straight from the bus, later stages from the
  // previous stage register.
  // NOTE: every output of an always_comb is assigned on every path (here
  // unconditionally up front) so no latch can be inferred.
  always_comb begin
    a_in[0] = bus.a;
    b_in[0] = b_first;
    c_in[0] = c_first;
    v_in[0] = bus.in_valid;
    for (int k = 1; k < NUM_BLK; k++) begin
      a_in[k] = a_q[k-1];
      b_in[k] = b_q[k-1];
      c_in[k] = ctl_q[k-1].carry;
      v_in[k] = ctl_q[k-1].valid;
    end
  end

  for (genvar g = 0; g < NUM_BLK; g++) begin : g_stage
    csa_block #(.BLK(BLK)) u_blk (
      .a         (a_in[g][g*BLK +: BLK]),
      .b         (b_in[g][g*BLK +: BLK]),
      .carry_in  (c_in[g]),
      .sum       (s_w[g]),
      .carry_out (co_w[g])
    );
  end

  // Next a-word per stage: the slice just resolved overwrites its operand bits.
  always_comb begin
    for (int k = 0; k < NUM_BLK; k++) begin
      a_nx[k]                = a_in[k];
      a_nx[k][k*BLK +: BLK]  = s_w[k];
    end
  end

`ifdef CSA_PIPE_SUB_EN
  logic ovf_nx;
  logic ovf_q;

  // Signed overflow: operands (b already conditioned) share a sign that the
  // final sum does not.
  assign ovf_nx = (a_in[LAST][WIDTH-1] == b_in[LAST][WIDTH-1]) &&
                  (s_w[LAST][BLK-1]   != a_in[LAST][WIDTH-1]);
  assign bus.ovf = ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (adv) begin
      ovf_q <= ovf_nx;
    end
  end
`endif

  // NOTE: the datapath registers are reset too, not just the valid bits,
  // because sum/cout must read 0 straight out of reset.
  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples the pre-edge value of its predecessor.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_BLK; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        ctl_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_BLK; k++) begin
        if (adv) begin
          a_q[k]         <= a_nx[k];
          b_q[k]         <= b_in[k];
          ctl_q[k].carry <= co_w[k];
          ctl_q[k].valid <= v_in[k];
        end
        // flush wins over adv; data may keep stale values behind valid=0.
        if (bus.flush) begin
          ctl_q[k].valid <= 1'b0;
        end
      end
    end
  end

  assign bus.out_valid = ctl_q[LAST].valid;
  assign bus.sum       = a_q[LAST];
  assign bus.cout      = ctl_q[LAST].carry;

endmodule

// File: tb/tb_csa_pipe_adder.sv
// ---------------------------------------------------------------------------
// tb_csa_pipe_adder
// Self-checking bench for csa_pipe_adder (WIDTH=32, BLK=8, latency 4).
// Directed vectors with hand-computed results, applied singly and as a
// back-to-back stream, plus hand-written backpressure, flush, async reset
// and (with CSA_PIPE_SUB_EN) subtract/overflow sequences.
// ---------------------------------------------------------------------------
module tb_csa_pipe_adder;
  localparam int WIDTH = 32;
  localparam int BLK   = 8;
  localparam int LAT   = 4;
  localparam int NV    = 16;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] sum;
    logic        cout;
  } vec_t;

  vec_t tbl [NV];

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  csa_pipe_adder_if #(.WIDTH(WIDTH)) bus ();

  csa_pipe_adder #(.WIDTH(WIDTH), .BLK(BLK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Move to just after the next rising edge; inputs are driven here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input int i);
    bus.a        = tbl[i].a;
    bus.b        = tbl[i].b;
    bus.cin      = tbl[i].cin;
    bus.in_valid = 1'b1;
  endtask

  // Offer the current operands for one cycle, then count edges until
  // out_valid (bounded).
  task automatic single_op(output int cycles);
    step();
    bus.in_valid = 1'b0;
    cycles = 1;
    while (!bus.out_valid && cycles < 20) begin
      step();
      cycles++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cyc;
    int w;
    int idx_in;
    int idx_out;
    int stall;
    bit started;

    tbl[0]  = '{32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0};
    tbl[1]  = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1};
    tbl[2]  = '{32'h00FF_FFFF, 32'h0000_0001, 1'b0, 32'h0100_0000, 1'b0};
    tbl[3]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1};
    tbl[4]  = '{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0};
    tbl[5]  = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0};
    tbl[6]  = '{32'h0000_FF00, 32'h0000_0100, 1'b0, 32'h0001_0000, 1'b0};
    tbl[7]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1};
    tbl[8]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0};
    tbl[9]  = '{32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF, 1'b0};
    tbl[10] = '{32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 32'h0000_0000, 1'b1};
    tbl[11] = '{32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b0, 32'hFFFF_FFFF, 1'b0};
    tbl[12] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0};
    tbl[13] = '{32'h89AB_CDEF, 32'h7654_3210, 1'b0, 32'hFFFF_FFFF, 1'b0};
    tbl[14] = '{32'h0101_0101, 32'h0101_0101, 1'b1, 32'h0202_0203, 1'b0};
    tbl[15] = '{32'hC000_0000, 32'h4000_0000, 1'b0, 32'h0000_0000, 1'b1};

    rst           = 1'b1;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b1;
`ifdef CSA_PIPE_SUB_EN
    bus.sub       = 1'b0;
`endif

    // ---- reset state
    #22;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_sum",       bus.sum,       0);
    check("rst_cout",      bus.cout,      0);
    check("rst_in_ready",  bus.in_ready,  1);
`ifdef CSA_PIPE_SUB_EN
    check("rst_ovf",       bus.ovf,       0);
`endif
    @(negedge clk);
    rst = 1'b0;
    step();

    // ---- isolated operations: latency, result, no duplicate
    for (int i = 0; i < NV; i++) begin
      present(i);
      single_op(cyc);
      check($sformatf("single_lat[%0d]", i),  cyc,      LAT);
      check($sformatf("single_sum[%0d]", i),  bus.sum,  tbl[i].sum);
      check($sformatf("single_cout[%0d]", i), bus.cout, tbl[i].cout);
      step();
      check($sformatf("single_nodup[%0d]", i), bus.out_valid, 0);
    end

    // ---- back-to-back stream, one result per cycle in order
    fork
      begin
        for (int i = 0; i < NV; i++) begin
          present(i);
          step();
        end
        bus.in_valid = 1'b0;
      end
      begin
        w = 0;
        @(negedge clk);
        while (!bus.out_valid && w < 20) begin
          @(negedge clk);
          w++;
        end
        for (int j = 0; j < NV; j++) begin
          check($sformatf("stream_valid[%0d]", j), bus.out_valid, 1);
          check($sformatf("stream_sum[%0d]", j),   bus.sum,       tbl[j].sum);
          check($sformatf("stream_cout[%0d]", j),  bus.cout,      tbl[j].cout);
          @(negedge clk);
        end
        check("stream_tail", bus.out_valid, 0);
      end
    join
    step();

    // ---- backpressure: stall 5 cycles after the first result
    idx_in  = 0;
    idx_out = 0;
    stall   = 0;
    started = 1'b0;
    for (int c = 0; c < 80 && idx_out < 8; c++) begin
      bus.in_valid = (idx_in < 8);
      if (idx_in < 8) begin
        bus.a   = tbl[idx_in].a;
        bus.b   = tbl[idx_in].b;
        bus.cin = tbl[idx_in].cin;
      end
      bus.out_ready = !(started && stall < 5);
      @(negedge clk);
      if (!bus.out_ready) begin
        check("bp_in_ready", bus.in_ready,  0);
        check("bp_hold_vld", bus.out_valid, 1);
        check("bp_hold_sum", bus.sum,       tbl[idx_out].sum);
        stall++;
      end
      if (bus.out_valid && bus.out_ready) begin
        check($sformatf("bp_sum[%0d]", idx_out),  bus.sum,  tbl[idx_out].sum);
        check($sformatf("bp_cout[%0d]", idx_out), bus.cout, tbl[idx_out].cout);
        idx_out++;
        started = 1'b1;
      end
      if (bus.in_valid && bus.in_ready) begin
        idx_in++;
      end
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check("bp_count", idx_out, 8);
    check("bp_stalls", stall, 5);
    repeat (5) step();
    check("bp_no_extra", bus.out_valid, 0);

    // ---- flush with 3 ops in flight; the op offered with flush is dropped
    for (int i = 0; i < 3; i++) begin
      present(i + 4);
      step();
    end
    present(2);
    bus.flush = 1'b1;
    #1;
    check("flush_in_ready", bus.in_ready, 1);
    step();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("flush_quiet[%0d]", k), bus.out_valid, 0);
    end
    step();
    present(9);
    single_op(cyc);
    check("post_flush_lat", cyc,     LAT);
    check("post_flush_sum", bus.sum, tbl[9].sum);
    step();

    // ---- async reset while a result is on the output
    for (int i = 4; i < 8; i++) begin
      present(i);
      step();
    end
    bus.in_valid = 1'b0;
    check("rst_mid_pre_vld", bus.out_valid, 1);
    check("rst_mid_pre_sum", bus.sum,       tbl[4].sum);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_vld",  bus.out_valid, 0);
    check("rst_mid_sum",  bus.sum,       0);
    check("rst_mid_cout", bus.cout,      0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("rst_mid_quiet[%0d]", k), bus.out_valid, 0);
    end
    step();

`ifdef CSA_PIPE_SUB_EN
    // ---- subtraction and signed overflow
    bus.a = 32'h8000_0000; bus.b = 32'h0000_0001; bus.cin = 1'b0;
    bus.sub = 1'b1; bus.in_valid = 1'b1;
    single_op(cyc);
    bus.sub = 1'b0;
    check("sub_ovf_lat",  cyc,      LAT);
    check("sub_ovf_sum",  bus.sum,  32'h7FFF_FFFF);
    check("sub_ovf_cout", bus.cout, 1);
    check("sub_ovf_flag", bus.ovf,  1);
    step();
    bus.a = 32'h0000_0005; bus.b = 32'h0000_0003; bus.cin = 1'b0;
    bus.sub = 1'b1; bus.in_valid = 1'b1;
    single_op(cyc);
    bus.sub = 1'b0;
    check("sub_sum",  bus.sum,  32'h0000_0002);
    check("sub_cout", bus.cout, 1);
    check("sub_flag", bus.ovf,  0);
    step();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/csa_pipe_adder.md
Name: csa_pipe_adder

Overview:
- Parametrised, pipelined carry-select adder. Successor to the fixed 8-bit combinational carry-select adder.
- Splits a WIDTH-bit add into NUM_BLK blocks of BLK bits, with one register stage per block. Each stage precomputes both carry-in variants of its block and selects with the registered carry from the previous stage.
- Sits in the datapath library as a drop-in streaming adder with valid/ready flow control.

Parameters:
- WIDTH, 32, operand/sum width in bits; must be a multiple of BLK, and at least BLK.
- BLK, 8, bits per carry-select block = bits resolved per pipeline stage.
- NUM_BLK, WIDTH/BLK, derived (localparam); stage count = latency in cycles.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- flush  input  1  synchronous clear of all in-flight operations
- in_valid  input  1  operands presented
- in_ready  output  1  block accepts operands this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry in
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  a+b+cin modulo 2^WIDTH
- cout  output  1  carry out of bit WIDTH-1

Behaviour:
- Reset:
  - All stage valid bits and registered data are 0.
  - Therefore out_valid=0, sum=0, cout=0.
  - in_ready=1 after reset.
- Global advance: adv = !out_valid || out_ready. in_ready = adv, combinational.
  - Bubbles are not collapsed; the whole pipe stalls as one.
- Transfer:
  - Input accepted when in_valid && in_ready.
  - Output consumed when out_valid && out_ready.
- Stage k (0..NUM_BLK-1), on adv:
  - Takes operand slice [k*BLK +: BLK] from its input register (stage 0: directly from a/b/cin).
  - Computes s0 = slice sum with carry 0 and s1 = slice sum with carry 1, each BLK+1 bits.
  - Selects with the incoming carry.
  - Registers: completed low sum bits, unprocessed high operand bits, carry, valid.
- Stage valid on adv:
  - v[0] <= in_valid (an input is accepted exactly when adv is high).
  - v[k] <= v[k-1].
- Stall: when adv=0, all registers hold, including out_valid, sum and cout.
- Latency: exactly NUM_BLK cycles from acceptance to out_valid, with no stall. Throughput 1 result per cycle.
- Result ordering is strictly FIFO.
- out_valid = v[NUM_BLK-1]. sum and cout are driven directly from the last stage registers, with no combinational path from a/b.
- flush:
  - Sets all v to 0 next edge, overriding adv.
  - Data registers may hold stale values. sum and cout are don't-care while out_valid=0.
  - An input offered during the flush cycle is dropped. in_ready still reflects adv.
- Simultaneous accept-and-consume with a full pipe: legal, no loss.
- Reset asserted mid-operation: all in-flight results are discarded immediately (async). No output is produced for them.
- NUM_BLK=1 degenerates to a single registered carry-select add. It must still obey the handshake.

Optional Feature:
- Macro: CSA_PIPE_SUB_EN.
- When defined:
  - Adds input port sub (1 bit), sampled with the operands.
  - When sub=1, stage 0 uses ~b and carry-in = !cin (cin acts as active-low borrow-in, so that cin=0 gives a-b).
  - Adds output ovf (1 bit, reset 0): signed overflow of the final result, aligned with out_valid.
- When undefined: no sub or ovf ports; pure addition.

Decomposition:
- Package csa_pipe_pkg:
  - function to compute NUM_BLK from WIDTH and BLK;
  - typedef for the per-stage carry/valid bundle;
  - elaboration-time check that WIDTH % BLK == 0.
- Sub-module csa_block:
  - combinational, parameter BLK;
  - inputs: a slice, b slice, carry_in;
  - outputs: sum slice, carry_out;
  - internally computes both carry variants and muxes.
- Top instantiates one csa_block per stage between registers.

Test Plan (WIDTH=32, BLK=8, latency 4):
- Reset, then a=0x0000_0001, b=0x0000_0002, cin=0, out_ready=1 -> out_valid high 4 cycles after accept, with sum=0x0000_0003, cout=0.
- Full carry ripple: a=0xFFFF_FFFF, b=0x0000_0000, cin=1 -> sum=0x0000_0000, cout=1. Also a=0x00FF_FFFF, b=1 -> sum=0x0100_0000, cout=0.
- Back-to-back stream of 16 random pairs with out_ready=1 -> 16 results in order, one per cycle, each matching the reference model.
- Backpressure: hold out_ready=0 for 5 cycles after the first result -> in_ready=0, and sum/out_valid stable. On release, all results appear in order with none lost or duplicated.
- flush with 3 ops in flight -> no out_valid next cycles. The next op accepted after flush returns its correct sum 4 cycles later.
- Async reset asserted mid-stream for 1 cycle -> out_valid=0, sum=0 immediately. With CSA_PIPE_SUB_EN: a=0x8000_0000, b=1, sub=1, cin=0 -> sum=0x7FFF_FFFF, ovf=1.
